// File: rtl/lvl_debouncer.sv
// Level debouncer: synchronizes an asynchronous raw level into the clk domain,
// then requires STABLE_CYCLES+1 consecutive agreeing samples before the
// registered output level follows. Aborted candidate transitions are counted
// in a saturating glitch counter.
module lvl_debouncer #(
   parameter int unsigned SYNC_STAGES      = 2,
   parameter int unsigned CNT_WIDTH        = 16,
   parameter int unsigned STABLE_CYCLES    = 1000,
   parameter int unsigned GLITCH_CNT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        RST,
   input  logic                        enable,
   input  logic                        raw_in,
   input  logic                        glitch_clr,
   output logic                        lvl_out,
   output logic                        settling,
   output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt
);

   // Encoding chosen so bit 1 is the debounced level and bit 0 marks a check
   // state; both outputs are then plain register bits with no decode delay.
   localparam logic [1:0] S_LOW      = 2'b00;
   localparam logic [1:0] S_RISE_CHK = 2'b01;
   localparam logic [1:0] S_HIGH     = 2'b10;
   localparam logic [1:0] S_FALL_CHK = 2'b11;

   localparam logic [CNT_WIDTH-1:0] STABLE_N = CNT_WIDTH'(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_in;
   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [CNT_WIDTH-1:0]   cnt_nxt;
   logic                   glitch_evt;

   // Synchronizer chain; shifts every cycle regardless of enable.
   always_ff @(posedge clk) begin
      if (RST) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

   // Next-state and stability-counter logic.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      glitch_evt = 1'b0;
      if (!enable) begin
         // Frozen: abandon any check and fall back to the current level.
         if (state == S_RISE_CHK) begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
         end else if (state == S_FALL_CHK) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
         end
      end else begin
         case (state)
            S_LOW: begin
               if (sync_in) begin
                  state_nxt = S_RISE_CHK;
                  cnt_nxt   = CNT_WIDTH'(1);
               end
            end
            S_RISE_CHK: begin
               if (!sync_in) begin
                  state_nxt  = S_LOW;
                  cnt_nxt    = '0;
                  glitch_evt = 1'b1;
               end else if (cnt == STABLE_N) begin
                  state_nxt = S_HIGH;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            S_HIGH: begin
               if (!sync_in) begin
                  state_nxt = S_FALL_CHK;
                  cnt_nxt   = CNT_WIDTH'(1);
               end
            end
            default: begin
               if (sync_in) begin
                  state_nxt  = S_HIGH;
                  cnt_nxt    = '0;
                  glitch_evt = 1'b1;
               end else if (cnt == STABLE_N) begin
                  state_nxt = S_LOW;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // State and stability counter registers.
   always_ff @(posedge clk) begin
      if (RST) begin
         state <= S_LOW;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Saturating glitch counter; clear wins over a simultaneous glitch.
   always_ff @(posedge clk) begin
      if (RST || glitch_clr)                 glitch_cnt <= '0;
      else if (glitch_evt && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
   end

   assign lvl_out  = state[1];
   assign settling = state[0];

endmodule

// File: tb/tb_lvl_debouncer.sv
// Directed bench for lvl_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4,
// GLITCH_CNT_WIDTH=2). Expected outputs are queued when each step is driven
// and popped/compared after the clock edge that step feeds.
module tb_lvl_debouncer;
   localparam int unsigned GW = 2;

   logic          clk = 1'b0;
   logic          RST = 1'b1;
   logic          enable = 1'b1;
   logic          raw_in = 1'b0;
   logic          glitch_clr = 1'b0;
   logic          lvl_out;
   logic          settling;
   logic [GW-1:0] glitch_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      string         tag;
      logic          lvl;
      logic          set;
      logic [GW-1:0] gc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   lvl_debouncer #(
      .SYNC_STAGES      (2),
      .CNT_WIDTH        (16),
      .STABLE_CYCLES    (4),
      .GLITCH_CNT_WIDTH (GW)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .enable     (enable),
      .raw_in     (raw_in),
      .glitch_clr (glitch_clr),
      .lvl_out    (lvl_out),
      .settling   (settling),
      .glitch_cnt (glitch_cnt)
   );

   // Drive one cycle of inputs, queue the outputs expected after the next
   // rising edge, then compare them 1 time unit past that edge.
   task automatic step(input logic rs, input logic en, input logic r, input logic clr,
                       input logic el, input logic es, input logic [GW-1:0] eg,
                       input string tag);
      exp_t e;
      RST        = rs;
      enable     = en;
      raw_in     = r;
      glitch_clr = clr;
      e.tag = tag;
      e.lvl = el;
      e.set = es;
      e.gc  = eg;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      assert (lvl_out === e.lvl) else begin
         bad++;
         $error("FAIL %s lvl_out got=%0b exp=%0b", e.tag, lvl_out, e.lvl);
      end
      total++;
      assert (settling === e.set) else begin
         bad++;
         $error("FAIL %s settling got=%0b exp=%0b", e.tag, settling, e.set);
      end
      total++;
      assert (glitch_cnt === e.gc) else begin
         bad++;
         $error("FAIL %s glitch_cnt got=%0d exp=%0d", e.tag, glitch_cnt, e.gc);
      end
   endtask

   // Clean transition to level v starting from a quiet sync chain: settling
   // after edges k+2..k+5, new level after edge k+6.
   task automatic run_edge(input logic v, input logic [GW-1:0] g, input string tag);
      for (int i = 0; i < 7; i++)
         step(1'b0, 1'b1, v, 1'b0, (i == 6) ? v : ~v, (i >= 2 && i <= 5), g, tag);
   endtask

   // From S_LOW: raw high for 3 cycles then low. Check runs after edges
   // k+2..k+4, sync_in reverts at edge k+5 which records the glitch.
   task automatic glitch(input logic [GW-1:0] g0, input logic [GW-1:0] g1,
                         input logic clr_last, input string tag);
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b1, (i < 3), (i == 5) ? clr_last : 1'b0,
              1'b0, (i >= 2 && i <= 4), (i == 5) ? g1 : g0, tag);
   endtask

   initial begin
      // Reset held with noisy input high.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "reset");

      // Release with raw_in still high, then clean fall.
      run_edge(1'b1, 2'd0, "rst_release");
      run_edge(1'b0, 2'd0, "fall");

      // Glitches: count 1,2,3,3,3 then clear beats a simultaneous glitch.
      glitch(2'd0, 2'd1, 1'b0, "glitch1");
      glitch(2'd1, 2'd2, 1'b0, "glitch2");
      glitch(2'd2, 2'd3, 1'b0, "glitch3");
      glitch(2'd3, 2'd3, 1'b0, "glitch4_sat");
      glitch(2'd3, 2'd3, 1'b0, "glitch5_sat");
      glitch(2'd3, 2'd0, 1'b1, "glitch_clr");

      // Non-zero count so the enable abort and the reset are visible on it.
      glitch(2'd0, 2'd1, 1'b0, "glitch_pre_en");

      // Start a rise check, then drop enable mid-check.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, "en_rise_start");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, "en_rise_start");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, "en_rise_chk");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, "en_rise_chk");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, "en_abort");
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b0, ((i % 3) != 0), 1'b0, 1'b0, 1'b0, 2'd1, "en_frozen");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "en_quiet");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "en_quiet");

      // Rise to high, start a fall check, then reset mid-check.
      run_edge(1'b1, 2'd1, "rise_after_en");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "fall_part");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "fall_part");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, "fall_chk");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "rst_mid_chk");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
